// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter serialising virtual-disk SD block requests onto one hps_io SD channel.
// Optional REQ-phase watchdog is enabled by defining SD_ARB_TIMEOUT_EN.
module sd_req_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned TO_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [32*NREQ-1:0] req_lba,
    input  logic [NREQ-1:0]    req_rd,
    input  logic [NREQ-1:0]    req_wr,
    output logic [NREQ-1:0]    req_ack,
    input  logic [8*NREQ-1:0]  req_buff_din,
    output logic [31:0]        sd_lba,
    output logic               sd_rd,
    output logic               sd_wr,
    input  logic               sd_ack,
    output logic [7:0]         sd_buff_din,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic               timeout
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [NREQ-1:0]  grant_nx;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] gnt_idx_nx;
    logic [PTR_W-1:0] rr_start;
    logic [PTR_W-1:0] rr_start_nx;
    logic [31:0]      sd_lba_nx;
    logic             sd_rd_nx;
    logic             sd_wr_nx;
    logic             timeout_nx;
    logic             to_expired;
    logic [PTR_W-1:0] sel_idx;
    logic             sel_found;
    int unsigned      scan_idx;

    if (NREQ < 1 || TO_W < 1) begin : g_param_chk
        $error("sd_req_arbiter: NREQ and TO_W must both be at least 1");
    end

    // First requesting client, scanning from rr_start with wrap-around
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = 32'(rr_start) + i;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!sel_found && (req_rd[PTR_W'(scan_idx)] || req_wr[PTR_W'(scan_idx)])) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(scan_idx);
            end
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Held at zero outside REQ so every REQ entry starts a fresh count
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state != REQ) begin
            to_cnt <= '0;
        end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign to_expired = (state == REQ) && (to_cnt == '1);
`else
    assign to_expired = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        gnt_idx_nx  = gnt_idx;
        rr_start_nx = rr_start;
        sd_lba_nx   = sd_lba;
        sd_rd_nx    = sd_rd;
        sd_wr_nx    = sd_wr;
        timeout_nx  = 1'b0;

        case (state)
            IDLE: begin
                // A lingering ack (e.g. after reset) must drain before a new grant
                if (!sd_ack && sel_found) begin
                    state_nx   = REQ;
                    grant_nx   = NREQ'(1) << sel_idx;
                    gnt_idx_nx = sel_idx;
                    sd_lba_nx  = req_lba[32*sel_idx +: 32];
                    sd_rd_nx   = req_rd[sel_idx];
                    sd_wr_nx   = req_wr[sel_idx] & ~req_rd[sel_idx];
                end
            end
            REQ: begin
                if (sd_ack) begin
                    state_nx = XFER;
                    sd_rd_nx = 1'b0;
                    sd_wr_nx = 1'b0;
                end else if (to_expired) begin
                    state_nx   = GAP;
                    sd_rd_nx   = 1'b0;
                    sd_wr_nx   = 1'b0;
                    timeout_nx = 1'b1;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_nx = GAP;
                end
            end
            GAP: begin
                state_nx    = IDLE;
                grant_nx    = '0;
                rr_start_nx = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                sd_rd_nx = 1'b0;
                sd_wr_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            gnt_idx  <= '0;
            rr_start <= '0;
            sd_lba   <= '0;
            sd_rd    <= 1'b0;
            sd_wr    <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            gnt_idx  <= gnt_idx_nx;
            rr_start <= rr_start_nx;
            sd_lba   <= sd_lba_nx;
            sd_rd    <= sd_rd_nx;
            sd_wr    <= sd_wr_nx;
            busy     <= (state_nx != IDLE);
            timeout  <= timeout_nx;
        end
    end

    // Zero-latency steering of ack and write data to the granted client
    assign req_ack = grant & {NREQ{sd_ack}};

    always_comb begin
        sd_buff_din = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sd_buff_din = sd_buff_din | req_buff_din[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Self-checking bench for sd_req_arbiter: cycle vector table, hand sequences and a randomized
// run against a transaction-level reference model. Timeout sequence runs with SD_ARB_TIMEOUT_EN.
module tb_sd_req_arbiter;

    localparam int NREQ    = 3;
    localparam int TB_TO_W = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [32*NREQ-1:0] req_lba = '0;
    logic [NREQ-1:0]   req_rd = '0;
    logic [NREQ-1:0]   req_wr = '0;
    logic [NREQ-1:0]   req_ack;
    logic [8*NREQ-1:0] req_buff_din = '0;
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack = 1'b0;
    logic [7:0]        sd_buff_din;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              timeout;

    int n_checks = 0;
    int n_err    = 0;

    sd_req_arbiter #(.NREQ(NREQ), .TO_W(TB_TO_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_lba      (req_lba),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_ack      (req_ack),
        .req_buff_din (req_buff_din),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .grant        (grant),
        .busy         (busy),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the channel and where that transaction is
    int          m_owner   = -1;
    int          m_start   = 0;
    bit          m_rd      = 1'b0;
    bit          m_wr      = 1'b0;
    bit          m_acked   = 1'b0;
    bit          m_gap     = 1'b0;
    bit          m_timeout = 1'b0;
    int          m_req_n   = 0;
    logic [31:0] m_lba     = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT sampled at this edge
    task automatic model_step();
        int c;
        m_timeout = 1'b0;
        if (reset) begin
            m_owner = -1; m_start = 0; m_rd = 1'b0; m_wr = 1'b0;
            m_acked = 1'b0; m_gap = 1'b0;
        end else if (m_gap) begin
            m_start = (m_owner + 1) % NREQ;
            m_owner = -1;
            m_gap   = 1'b0;
        end else if (m_owner < 0) begin
            if (!sd_ack) begin
                for (int k = 0; k < NREQ; k++) begin
                    c = (m_start + k) % NREQ;
                    if (m_owner < 0 && (req_rd[c] || req_wr[c])) begin
                        m_owner = c;
                        m_lba   = req_lba[32*c +: 32];
                        m_rd    = req_rd[c];
                        m_wr    = req_wr[c] && !req_rd[c];
                        m_acked = 1'b0;
                        m_req_n = 0;
                    end
                end
            end
        end else if (!m_acked) begin
            if (sd_ack) begin
                m_acked = 1'b1; m_rd = 1'b0; m_wr = 1'b0;
            end else begin
                m_req_n++;
`ifdef SD_ARB_TIMEOUT_EN
                if (m_req_n == (1 << TB_TO_W)) begin
                    m_rd = 1'b0; m_wr = 1'b0; m_timeout = 1'b1; m_gap = 1'b1;
                end
`endif
            end
        end else if (!sd_ack) begin
            m_gap = 1'b1;
        end
    endtask

    task automatic model_compare();
        logic [2:0] eg;
        logic [7:0] eb;
        eg = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
        eb = (m_owner >= 0) ? req_buff_din[8*m_owner +: 8] : 8'h00;
        check("model_ctl", 64'({grant, sd_rd, sd_wr, busy, timeout, req_ack}),
              64'({eg, m_rd, m_wr, (m_owner >= 0), m_timeout, eg & {3{sd_ack}}}));
        check("model_buff", 64'(sd_buff_din), 64'(eb));
        if (m_owner >= 0) check("model_lba", 64'(sd_lba), 64'(m_lba));
    endtask

    // One clock: model follows the edge, DUT is sampled on the falling edge
    task automatic cycle_step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_compare();
    endtask

    typedef struct packed {
        logic       rst;
        logic [2:0] rd;
        logic [2:0] wr;
        logic       ack;
        logic [2:0] g;
        logic       srd;
        logic       swr;
        logic       busy;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic [2:0] rd, input logic [2:0] wr,
                               input logic ack, input logic [2:0] g, input logic srd,
                               input logic swr, input logic b);
        vec_t r;
        r.rst = rst; r.rd = rd; r.wr = wr; r.ack = ack;
        r.g = g; r.srd = srd; r.swr = swr; r.busy = b;
        return r;
    endfunction

    // Random environment: clients hold requests until acked, host acks after a short delay
    bit h_armed = 1'b0;
    int h_delay = 0;
    int h_len   = 0;

    task automatic drive_random();
        int kind;
        reset = ($urandom_range(0, 299) == 0);
        for (int i = 0; i < NREQ; i++) begin
            if (req_rd[i] || req_wr[i]) begin
                if (req_ack[i]) begin
                    req_rd[i] = 1'b0; req_wr[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req_lba[32*i +: 32] = $urandom;
                end
            end else if ($urandom_range(0, 5) == 0) begin
                kind = $urandom_range(1, 3);
                req_rd[i] = kind[0];
                req_wr[i] = kind[1];
                req_lba[32*i +: 32] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) req_buff_din[8*i +: 8] = 8'($urandom);
        end
        if (sd_ack) begin
            if (h_len == 0) sd_ack = 1'b0;
            else h_len--;
        end else if (h_armed) begin
            if (h_delay == 0) begin
                sd_ack = 1'b1; h_len = $urandom_range(0, 6); h_armed = 1'b0;
            end else begin
                h_delay--;
            end
        end else if (sd_rd || sd_wr) begin
            h_armed = 1'b1; h_delay = $urandom_range(0, 3);
        end
    endtask

    initial begin
        vec_t tbl[$];
        int   bad;
        int   n;

        req_lba      = {32'h0000_2200, 32'h0000_1234, 32'h0000_0100};
        req_buff_din = {8'hA5, 8'h22, 8'h11};

        //             rst   rd      wr      ack   grant   rd    wr    busy
        tbl.push_back(v(1'b1, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b010, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b1, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b111, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b111, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b110, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b110, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b110, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b110, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b100, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b100, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b100, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b100, 3'b000, 1'b1, 3'b100, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b100, 3'b100, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b100, 3'b100, 1'b1, 3'b100, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b100, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b000, 3'b100, 1'b0, 3'b100, 1'b0, 1'b1, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b100, 1'b1, 3'b100, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b1, 3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b101, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b101, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b101, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b101, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b101, 3'b000, 1'b1, 3'b100, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b001, 3'b000, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b001, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(v(1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1));
        tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0));

        @(negedge clk);
        foreach (tbl[i]) begin
            reset  = tbl[i].rst;
            req_rd = tbl[i].rd;
            req_wr = tbl[i].wr;
            sd_ack = tbl[i].ack;
            cycle_step();
            check($sformatf("vec%0d", i), 64'({grant, sd_rd, sd_wr, busy, req_ack}),
                  64'({tbl[i].g, tbl[i].srd, tbl[i].swr, tbl[i].busy, tbl[i].g & {3{tbl[i].ack}}}));
            if (tbl[i].g[2] && busy) check($sformatf("vec%0d_buff", i), 64'(sd_buff_din), 64'(8'hA5));
        end

        // HDD read with a 512-cycle ack
        req_rd = 3'b010;
        cycle_step();
        check("hdd_grant", 64'({grant, sd_rd, sd_lba}), 64'({3'b010, 1'b1, 32'h0000_1234}));
        sd_ack = 1'b1;
        cycle_step();
        check("hdd_rd_drop", 64'(sd_rd), 64'(1'b0));
        req_rd = 3'b000;
        bad = 0;
        for (int i = 0; i < 511; i++) begin
            if (req_ack !== 3'b010) bad++;
            cycle_step();
        end
        check("hdd_ack_mirror", 64'(bad), 64'(0));
        sd_ack = 1'b0;
        cycle_step();
        check("hdd_busy_gap", 64'({busy, req_ack}), 64'({1'b1, 3'b000}));
        cycle_step();
        check("hdd_busy_fall", 64'({busy, grant}), 64'({1'b0, 3'b000}));

`ifdef SD_ARB_TIMEOUT_EN
        // Unanswered request: watchdog fires, then the next client is served
        req_rd = 3'b001;
        n = 0;
        while (!timeout && n < 40) begin
            cycle_step();
            n++;
            if (n == 2) req_rd = 3'b011;
        end
        check("to_cycles", 64'(n), 64'(17));
        check("to_rd_drop", 64'({sd_rd, timeout}), 64'({1'b0, 1'b1}));
        n = 0;
        while (grant !== 3'b010 && n < 10) begin
            cycle_step();
            n++;
        end
        check("to_next_grant", 64'({grant, sd_rd}), 64'({3'b010, 1'b1}));
        sd_ack = 1'b1;
        cycle_step();
        req_rd = 3'b000;
        sd_ack = 1'b0;
        cycle_step();
        cycle_step();
`endif

        // Randomized traffic against the model
        req_rd = '0; req_wr = '0; sd_ack = 1'b0; reset = 1'b1;
        cycle_step();
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            cycle_step();
            drive_random();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
